// File: rtl/copy_burst_scheduler.sv
// Splits one copy descriptor into paired read/write burst commands, throttled by write-completion credits.
// Optional `COPY_SCHED_PAGE_SPLIT_EN: bursts never cross a 4KB page on either src or dst.
module copy_burst_scheduler #(
  parameter int MAX_BURST_CNT      = 64,
  parameter int MAX_REQS_IN_FLIGHT = 1024,
  parameter int ADDR_W             = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [ADDR_W-1:0] desc_src_addr,
  input  logic [ADDR_W-1:0] desc_dst_addr,
  input  logic [31:0]       desc_num_lines,
  output logic              rd_cmd_valid,
  input  logic              rd_cmd_ready,
  output logic [ADDR_W-1:0] rd_cmd_addr,
  output logic [8:0]        rd_cmd_lines,
  output logic              wr_cmd_valid,
  input  logic              wr_cmd_ready,
  output logic [ADDR_W-1:0] wr_cmd_addr,
  output logic [8:0]        wr_cmd_lines,
  input  logic              wr_cpl_valid,
  output logic              busy,
  output logic              done,
  output logic [10:0]       in_flight,
  output logic              cpl_underflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] src, dst, src_n, dst_n;
  logic [31:0]       rem, rem_n;
  logic [8:0]        len, len_n;
  logic              rd_vld, wr_vld, pair_act;
  logic              rd_fire, wr_fire, pair_done, cpl_ok, present;
  logic [10:0]       inf_n;
`ifdef COPY_SCHED_PAGE_SPLIT_EN
  logic [6:0]        src_room, dst_room;
`endif

  assign desc_ready   = (state == IDLE) & ~reset;
  assign busy         = (state != IDLE);
  assign rd_cmd_valid = rd_vld;
  assign wr_cmd_valid = wr_vld;
  assign rd_cmd_addr  = src;
  assign wr_cmd_addr  = dst;
  assign rd_cmd_lines = len;
  assign wr_cmd_lines = len;

  // Next-burst fields are derived from post-handshake values so the following
  // burst can be presented in the cycle right after a pair completes.
  always_comb begin
    rd_fire   = rd_vld & rd_cmd_ready;
    wr_fire   = wr_vld & wr_cmd_ready;
    pair_done = pair_act & (rd_fire | ~rd_vld) & (wr_fire | ~wr_vld);
    cpl_ok    = wr_cpl_valid & (in_flight != 11'd0);
    inf_n     = in_flight + 11'(pair_done) - 11'(cpl_ok);
    src_n     = src;
    dst_n     = dst;
    rem_n     = rem;
    if (pair_done) begin
      src_n = src + (ADDR_W'(len) << 6);
      dst_n = dst + (ADDR_W'(len) << 6);
      rem_n = rem - 32'(len);
    end
    len_n = (rem_n >= 32'(MAX_BURST_CNT)) ? 9'(MAX_BURST_CNT) : rem_n[8:0];
`ifdef COPY_SCHED_PAGE_SPLIT_EN
    src_room = 7'd64 - 7'(src_n[11:6]);
    dst_room = 7'd64 - 7'(dst_n[11:6]);
    if (len_n > 9'(src_room)) len_n = 9'(src_room);
    if (len_n > 9'(dst_room)) len_n = 9'(dst_room);
`endif
    present = (state == ISSUE) & (~pair_act | pair_done) & (rem_n != 32'd0) &
              (32'(inf_n) < MAX_REQS_IN_FLIGHT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      src           <= '0;
      dst           <= '0;
      rem           <= '0;
      len           <= '0;
      rd_vld        <= 1'b0;
      wr_vld        <= 1'b0;
      pair_act      <= 1'b0;
      done          <= 1'b0;
      in_flight     <= '0;
      cpl_underflow <= 1'b0;
    end else begin
      done      <= 1'b0;
      in_flight <= inf_n;
      src       <= src_n;
      dst       <= dst_n;
      rem       <= rem_n;
      if (wr_cpl_valid && in_flight == 11'd0) cpl_underflow <= 1'b1;
      if (present) begin
        rd_vld   <= 1'b1;
        wr_vld   <= 1'b1;
        pair_act <= 1'b1;
        len      <= len_n;
      end else begin
        if (rd_fire)   rd_vld   <= 1'b0;
        if (wr_fire)   wr_vld   <= 1'b0;
        if (pair_done) pair_act <= 1'b0;
      end
      case (state)
        IDLE: if (desc_valid) begin
          if (desc_num_lines == 32'd0) begin
            done <= 1'b1;
          end else begin
            src   <= desc_src_addr;
            dst   <= desc_dst_addr;
            rem   <= desc_num_lines;
            state <= ISSUE;
          end
        end
        ISSUE: if (pair_done && rem_n == 32'd0) state <= DRAIN;
        DRAIN: if (in_flight == 11'd0) begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
